stopwatch_core: RTL
===================

# stopwatch_core

Stopwatch datapath and control that produces the running time for the FND display stage. It contains a run/stop/clear state machine, a 100 Hz tick prescaler, and cascaded msec (centisecond), sec, min and hour counters. The binary outputs connect directly to the display controller's `msec`/`sec`/`min`/`hour` inputs. The command inputs come from the button debouncers as single-cycle pulses.

## Interface
Parameters:
- `CLK_FREQ`, default 100_000_000: system clock frequency in Hz.
- `TICK_HZ`, default 100: msec-counter increment rate in Hz.
  - `DIV = CLK_FREQ / TICK_HZ`.
  - `CLK_FREQ` must be divisible by `TICK_HZ`, and `DIV` must be at least 2.

Ports:
- `clk` input 1: system clock. One clock; all state updates on its rising edge.
- `rst` input 1: reset. Synchronous and active-high.
- `i_run_stop` input 1: single-cycle pulse that toggles run/stop.
- `i_clear` input 1: single-cycle pulse that zeroes the time. It is honoured only while stopped.
- `o_msec` output 7: hundredths of a second, 0..99.
- `o_sec` output 6: seconds, 0..59.
- `o_min` output 6: minutes, 0..59.
- `o_hour` output 5: hours, 0..23.
- `o_running` output 1: high while the state is RUN.

## Operation
- FSM states:
  - STOP: reset state.
  - RUN.
  - CLEAR.
- Transitions, evaluated on every rising edge:
  - STOP with `i_run_stop` goes to RUN.
  - STOP with `i_clear` (and no `i_run_stop`) goes to CLEAR.
  - STOP with both asserted: `i_run_stop` wins and the state goes to RUN. The clear is dropped.
  - RUN with `i_run_stop` goes to STOP. `i_clear` is ignored in RUN.
  - CLEAR goes to STOP unconditionally. Any pulse that arrives while in CLEAR is ignored.
- Prescaler (width `$clog2(DIV)`):
  - In RUN it counts 0..DIV-1 and wraps.
  - In STOP it holds, so a partial tick is preserved across a stop/resume.
  - In CLEAR it is zeroed.
- `tick` is a combinational signal, equal to (state==RUN && prescaler==DIV-1).
- Counter cascade, all steps on the same edge:
  - msec increments on `tick`.
  - sec increments on (`tick` && msec==99).
  - min increments on (sec carry && sec==59).
  - hour increments on (min carry && min==59).
  - Each counter wraps to 0 on its carry.
  - hour wraps 23 to 0 with no further carry; the time rolls over to 00:00:00.00.
- In CLEAR, all four counters load 0.
- Counters are not otherwise writable.
- Outputs are the counter registers themselves: registered, with no combinational path from the inputs.

## Timing
- Reset values:
  - State STOP, prescaler 0.
  - `o_msec`, `o_sec`, `o_min`, `o_hour` all 0.
  - `o_running` 0.
- `i_run_stop` sampled high at edge k (from STOP): `o_running`=1 after edge k.
- Run from a zeroed prescaler: the first msec increment is visible after edge k+DIV. Each subsequent increment follows every DIV cycles.
- Stop while running: `i_run_stop` at edge k moves the state to STOP after edge k.
  - If `tick` is true at edge k, that increment still takes effect.
  - No increment occurs after edge k.
- Clear in STOP: `i_clear` at edge k gives state CLEAR after edge k. Counters and prescaler are 0 and the state is STOP after edge k+1.
- `rst` asserted mid-RUN: on the next edge everything returns to its reset value. Any pulse coincident with `rst` is ignored.
- Full rollover at 23:59:59.99: the next `tick` zeroes all four counters on a single edge.

## Structure
- Shared package `stopwatch_pkg` holds:
  - State encoding localparams: STOP=2'd0, RUN=2'd1, CLEAR=2'd2.
  - Limits: MSEC_MAX=99, SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23.
  - Output widths 7/6/6/5, shared with the display controller.
- Sub-module `sw_time_counter`:
  - Parameters: `WIDTH`, `MAX`.
  - Ports: `clk`, `rst`, `i_inc`, `i_clear`, `o_count`, `o_carry`.
  - `o_carry` = `i_inc` && `o_count`==MAX.
  - Instantiated four times, chained carry to `i_inc`.
- The top level contains the FSM and prescaler.

## Test plan
All scenarios use `CLK_FREQ`=1000 and `TICK_HZ`=100, so DIV=10.
- Reset, then idle for 50 cycles: all outputs stay 0 and `o_running`=0.
- `i_run_stop` pulse, then 1000 cycles: `o_msec` increments every 10 cycles, reaching 99. The next tick gives msec=0 and sec=1.
- Run for 35 cycles, stop, idle 100 cycles, resume: `o_msec`=3 throughout the idle period. The next increment arrives 5 cycles after resume.
- Pulse `i_clear` while running: ignored, counting continues. Stop, then pulse `i_clear`: outputs read 0 two edges later and the state is STOP.
- Preload via a long run or force to 23:59:59.98, then run for two ticks: 23:59:59.99, then 00:00:00.00 with all fields changing on one edge.
- Simultaneous `i_run_stop` and `i_clear` in STOP: enters RUN and the counters are not cleared. Assert `rst` mid-run: all outputs are 0 after the next edge.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared encodings, counter limits and field widths for the stopwatch and its display controller.
// Pure declarations: no latency, no flow control.
package stopwatch_pkg;

  localparam logic [1:0] STOP  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] CLEAR = 2'd2;

  typedef enum logic [1:0] {
    ST_STOP  = STOP,
    ST_RUN   = RUN,
    ST_CLEAR = CLEAR
  } state_t;

  localparam int MSEC_MAX = 99;
  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;

  localparam int MSEC_W = 7;
  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

endpackage

// File: rtl/stopwatch_if.sv
// Command pulses in, running time out; the core uses the slave view, debouncers/display the master view.
// Wires only: no latency, no backpressure (commands are fire-and-forget pulses).
interface stopwatch_if;
  import stopwatch_pkg::*;

  logic              i_run_stop;
  logic              i_clear;
  logic [MSEC_W-1:0] o_msec;
  logic [SEC_W-1:0]  o_sec;
  logic [MIN_W-1:0]  o_min;
  logic [HOUR_W-1:0] o_hour;
  logic              o_running;

  modport master (
    output i_run_stop, i_clear,
    input  o_msec, o_sec, o_min, o_hour, o_running
  );

  modport slave (
    input  i_run_stop, i_clear,
    output o_msec, o_sec, o_min, o_hour, o_running
  );

endinterface

// File: rtl/sw_time_counter.sv
// Modulo-(MAX+1) counter with synchronous clear; carry is combinational from i_inc.
// Count updates one cycle after i_inc; no backpressure.
module sw_time_counter #(
  parameter int WIDTH = 7,
  parameter int MAX   = 99
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_clear,
  output logic [WIDTH-1:0] o_count,
  output logic             o_carry
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  assign o_carry = i_inc && (o_count == MAX_V);

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      o_count <= '0;
    end else if (i_inc) begin
      o_count <= o_carry ? '0 : o_count + 1'b1;
    end
  end

endmodule

// File: rtl/stopwatch_core.sv
// Run/stop/clear FSM, 100 Hz prescaler and cascaded msec/sec/min/hour counters.
// Outputs registered, one edge after the causing tick/command; no backpressure.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int TICK_HZ  = 100
) (
  input  logic clk,
  input  logic rst,
  stopwatch_if.slave sw
);

  localparam int DIV   = CLK_FREQ / TICK_HZ;
  localparam int PSC_W = $clog2(DIV);
  localparam logic [PSC_W-1:0] PSC_MAX = PSC_W'(DIV - 1);

  state_t           state;
  logic             running;
  logic [PSC_W-1:0] psc;
  logic             tick;
  logic             clr;
  logic             msec_carry;
  logic             sec_carry;
  logic             min_carry;
  logic             hour_carry_unused;

  assign tick         = (state == ST_RUN) && (psc == PSC_MAX);
  assign clr          = (state == ST_CLEAR);
  assign sw.o_running = running;

  // The prescaler also advances on the stopping edge, so a resume picks up
  // exactly where the stopped tick left off.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_STOP;
      running <= 1'b0;
      psc     <= '0;
    end else begin
      case (state)
        ST_STOP: begin
          if (sw.i_run_stop) begin
            state   <= ST_RUN;
            running <= 1'b1;
          end else if (sw.i_clear) begin
            state   <= ST_CLEAR;
          end
        end
        ST_RUN: begin
          psc <= (psc == PSC_MAX) ? '0 : psc + 1'b1;
          if (sw.i_run_stop) begin
            state   <= ST_STOP;
            running <= 1'b0;
          end
        end
        ST_CLEAR: begin
          psc     <= '0;
          state   <= ST_STOP;
          running <= 1'b0;
        end
        default: begin
          state   <= ST_STOP;
          running <= 1'b0;
          psc     <= '0;
        end
      endcase
    end
  end

  sw_time_counter #(.WIDTH(MSEC_W), .MAX(MSEC_MAX)) u_msec (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (tick),
    .i_clear (clr),
    .o_count (sw.o_msec),
    .o_carry (msec_carry)
  );

  sw_time_counter #(.WIDTH(SEC_W), .MAX(SEC_MAX)) u_sec (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (msec_carry),
    .i_clear (clr),
    .o_count (sw.o_sec),
    .o_carry (sec_carry)
  );

  sw_time_counter #(.WIDTH(MIN_W), .MAX(MIN_MAX)) u_min (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (sec_carry),
    .i_clear (clr),
    .o_count (sw.o_min),
    .o_carry (min_carry)
  );

  sw_time_counter #(.WIDTH(HOUR_W), .MAX(HOUR_MAX)) u_hour (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (min_carry),
    .i_clear (clr),
    .o_count (sw.o_hour),
    .o_carry (hour_carry_unused)
  );

endmodule
